// File: rtl/a_skew_feeder.sv
// a_skew_feeder: accepts NUM_ROWS-wide A vectors over valid/ready and applies
// the diagonal systolic skew (lane i delayed by i advances) toward the PE array.
// After the final beat it injects zero vectors until the skew is flushed,
// then pulses done. ARRAY_EN marks every cycle in which A_left holds a new advance.
module a_skew_feeder #(
  parameter int unsigned NUM_ROWS = 16,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned K_MAX    = 256,
  localparam int unsigned CW      = $clog2(K_MAX + 1)
) (
  input  logic                       CLK,
  input  logic                       RESET,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       in_last,
  input  logic [NUM_ROWS*DATA_W-1:0] in_data,
  output logic [NUM_ROWS*DATA_W-1:0] A_left,
  output logic                       ARRAY_EN,
  output logic                       busy,
  output logic                       done,
  output logic [CW-1:0]              beat_count,
  output logic                       overflow
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_STREAM = 2'd1;
  localparam logic [1:0] ST_DRAIN  = 2'd2;

  localparam int unsigned   DCW        = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
  localparam logic [DCW-1:0] DRAIN_LAST = DCW'((NUM_ROWS > 1) ? (NUM_ROWS - 2) : 0);
  localparam logic [CW-1:0]  KMAX_C     = CW'(K_MAX);

  logic [1:0]     state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d, cnt_next;
  logic           ovf_q, ovf_d;
  logic [DCW-1:0] drain_q, drain_d;
  logic           done_q, done_d;
  logic           en_q;

  logic                       fire;
  logic                       adv;
  logic [NUM_ROWS*DATA_W-1:0] feed;

  assign in_ready   = (state_q != ST_DRAIN);
  assign fire       = in_valid & in_ready;
  assign adv        = fire | (state_q == ST_DRAIN);
  assign feed       = fire ? in_data : '0;
  assign cnt_next   = (state_q == ST_IDLE) ? CW'(1) : cnt_q + CW'(1);

  assign busy       = (state_q != ST_IDLE);
  assign done       = done_q;
  assign ARRAY_EN   = en_q;
  assign beat_count = cnt_q;
  assign overflow   = ovf_q;

  // Next-state, beat counting, overflow and drain sequencing.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    drain_d = drain_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE, ST_STREAM: begin
        if (fire) begin
          cnt_d = cnt_next;
          if (state_q == ST_IDLE) ovf_d = 1'b0;
          if (in_last || (cnt_next == KMAX_C)) begin
            // Truncated at K_MAX without a last marker.
            if (!in_last) ovf_d = 1'b1;
            drain_d = '0;
            if (NUM_ROWS == 1) begin
              state_d = ST_IDLE;
              done_d  = 1'b1;
            end else begin
              state_d = ST_DRAIN;
            end
          end else begin
            state_d = ST_STREAM;
          end
        end
      end
      ST_DRAIN: begin
        drain_d = drain_q + DCW'(1);
        if (drain_q == DRAIN_LAST) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Control state registers; ARRAY_EN is registered alongside the data advance.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      drain_q <= '0;
      done_q  <= 1'b0;
      en_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      drain_q <= drain_d;
      done_q  <= done_d;
      en_q    <= adv;
    end
  end

  for (genvar i = 0; i < NUM_ROWS; i++) begin : g_lane
    logic [DATA_W-1:0] chain_q [i+1];

    // Lane i shift chain of i+1 stages; stage i drives the array.
    always_ff @(posedge CLK) begin
      if (RESET) begin
        chain_q <= '{default: '0};
      end else if (adv) begin
        chain_q[0] <= feed[i*DATA_W +: DATA_W];
        for (int unsigned s = 1; s <= i; s++) chain_q[s] <= chain_q[s-1];
      end
    end

    assign A_left[i*DATA_W +: DATA_W] = chain_q[i];
  end

endmodule

// File: tb/tb_a_skew_feeder.sv
// Bench for a_skew_feeder: three instances (4 rows/K_MAX 8, 4 rows/K_MAX 4,
// 16 rows/K_MAX 256) share stimulus; only the selected one sees in_valid.
module tb_a_skew_feeder;

  logic        CLK = 1'b0;
  logic        RESET, in_valid, in_last;
  logic [15:0] lane_d [16];
  int          sel;

  logic [63:0]  data4;
  logic [255:0] data16;

  always_comb begin
    data4  = '0;
    data16 = '0;
    for (int i = 0; i < 4; i++)  data4[i*16 +: 16]  = lane_d[i];
    for (int i = 0; i < 16; i++) data16[i*16 +: 16] = lane_d[i];
  end

  logic        r0_ready, r0_en, r0_busy, r0_done, r0_ovf;
  logic [63:0] r0_a;
  logic [3:0]  r0_cnt;
  logic        r1_ready, r1_en, r1_busy, r1_done, r1_ovf;
  logic [63:0] r1_a;
  logic [2:0]  r1_cnt;
  logic        r2_ready, r2_en, r2_busy, r2_done, r2_ovf;
  logic [255:0] r2_a;
  logic [8:0]  r2_cnt;

  a_skew_feeder #(.NUM_ROWS(4), .DATA_W(16), .K_MAX(8)) u_r4k8 (
    .CLK(CLK), .RESET(RESET), .in_valid(in_valid && sel == 0), .in_ready(r0_ready),
    .in_last(in_last), .in_data(data4), .A_left(r0_a), .ARRAY_EN(r0_en),
    .busy(r0_busy), .done(r0_done), .beat_count(r0_cnt), .overflow(r0_ovf));

  a_skew_feeder #(.NUM_ROWS(4), .DATA_W(16), .K_MAX(4)) u_r4k4 (
    .CLK(CLK), .RESET(RESET), .in_valid(in_valid && sel == 1), .in_ready(r1_ready),
    .in_last(in_last), .in_data(data4), .A_left(r1_a), .ARRAY_EN(r1_en),
    .busy(r1_busy), .done(r1_done), .beat_count(r1_cnt), .overflow(r1_ovf));

  a_skew_feeder #(.NUM_ROWS(16), .DATA_W(16), .K_MAX(256)) u_r16 (
    .CLK(CLK), .RESET(RESET), .in_valid(in_valid && sel == 2), .in_ready(r2_ready),
    .in_last(in_last), .in_data(data16), .A_left(r2_a), .ARRAY_EN(r2_en),
    .busy(r2_busy), .done(r2_done), .beat_count(r2_cnt), .overflow(r2_ovf));

  always #5 CLK = ~CLK;

  logic         obs_ready, obs_en, obs_busy, obs_done, obs_ovf;
  logic [255:0] obs_a;
  logic [8:0]   obs_cnt;

  always_comb begin
    obs_ready = 1'b0; obs_en = 1'b0; obs_busy = 1'b0; obs_done = 1'b0;
    obs_ovf = 1'b0; obs_a = '0; obs_cnt = '0;
    case (sel)
      0: begin
        obs_ready = r0_ready; obs_en = r0_en; obs_busy = r0_busy; obs_done = r0_done;
        obs_ovf = r0_ovf; obs_a = {192'b0, r0_a}; obs_cnt = 9'(r0_cnt);
      end
      1: begin
        obs_ready = r1_ready; obs_en = r1_en; obs_busy = r1_busy; obs_done = r1_done;
        obs_ovf = r1_ovf; obs_a = {192'b0, r1_a}; obs_cnt = 9'(r1_cnt);
      end
      default: begin
        obs_ready = r2_ready; obs_en = r2_en; obs_busy = r2_busy; obs_done = r2_done;
        obs_ovf = r2_ovf; obs_a = r2_a; obs_cnt = r2_cnt;
      end
    endcase
  end

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_note(input string name);
    n_vec++;
    n_bad++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // Reference: lane i on advance n carries beat (n-1-i), zero outside the stream.
  function automatic logic [15:0] elem(input int base, input int j, input int i);
    if (base < 0) return 16'hAAAA;
    return 16'(base + 16 * j + i);
  endfunction

  logic [255:0] exp_q [$];

  task automatic push_expected(input int base, input int nr, input int k);
    logic [255:0] v;
    for (int n = 1; n <= k + nr - 1; n++) begin
      v = '0;
      for (int i = 0; i < nr; i++) begin
        if ((n - 1 - i) >= 0 && (n - 1 - i) < k) v[i*16 +: 16] = elem(base, n - 1 - i, i);
      end
      exp_q.push_back(v);
    end
  endtask

  // Monitor: pop one expected vector per advance, check holds during stalls.
  logic         mon_on = 1'b0;
  int           adv_cnt = 0;
  int           done_cnt = 0;
  logic [255:0] prev_a = '0;
  logic [255:0] ev_m;
  logic [15:0]  hist0 [64];
  logic [15:0]  hist3 [64];

  always @(negedge CLK) begin
    if (mon_on) begin
      if (obs_en) begin
        adv_cnt++;
        if (adv_cnt < 64) begin
          hist0[adv_cnt] = obs_a[15:0];
          hist3[adv_cnt] = obs_a[63:48];
        end
        if (exp_q.size() == 0) fail_note("extra_advance");
        else begin
          ev_m = exp_q.pop_front();
          check("a_left_adv", obs_a, ev_m);
        end
      end else if (obs_busy) begin
        check("stall_hold", obs_a, prev_a);
      end
      if (obs_done) done_cnt++;
    end
    prev_a = obs_a;
  end

  task automatic drive_beat(input int base, input int j, input bit last);
    int t;
    for (int i = 0; i < 16; i++) lane_d[i] = elem(base, j, i);
    in_last  = last;
    in_valid = 1'b1;
    t = 0;
    while (!obs_ready && t < 100) begin
      @(negedge CLK);
      t++;
    end
    if (t >= 100) fail_note("accept_timeout");
    @(negedge CLK);
  endtask

  task automatic finish_stream();
    int t;
    in_valid = 1'b0;
    in_last  = 1'b0;
    t = 0;
    while (obs_busy && t < 100) begin
      @(negedge CLK);
      t++;
    end
    if (t >= 100) fail_note("drain_timeout");
    repeat (2) @(negedge CLK);
  endtask

  typedef struct {
    int sel;
    int base;
    int nbeats;
    int gap;
    bit use_last;
    int exp_cnt;
    bit exp_ovf;
    int exp_adv;
  } vec_t;

  vec_t tbl [5];
  int   l0_ref [6];
  int   l3_ref [6];

  task automatic run_stream(input vec_t v);
    int nr, kmax, k;
    sel = v.sel;
    #1;
    nr   = (v.sel == 2) ? 16 : 4;
    kmax = (v.sel == 0) ? 8 : (v.sel == 1) ? 4 : 256;
    k    = (v.nbeats < kmax) ? v.nbeats : kmax;
    exp_q.delete();
    push_expected(v.base, nr, k);
    adv_cnt  = 0;
    done_cnt = 0;
    mon_on   = 1'b1;
    for (int j = 0; j < v.nbeats; j++) begin
      if (j == 1 && v.gap > 0) begin
        in_valid = 1'b0;
        repeat (v.gap) @(negedge CLK);
      end
      if (j == kmax) begin
        // Producer keeps offering the next beat; it must be refused all drain long.
        for (int i = 0; i < 16; i++) lane_d[i] = elem(v.base, j, i);
        in_valid = 1'b1;
        in_last  = 1'b0;
        for (int c = 0; c <= nr - 2; c++) begin
          check("ovf_in_ready_low", obs_ready, 0);
          if (c < nr - 2) @(negedge CLK);
        end
        break;
      end
      drive_beat(v.base, j, v.use_last && (j == v.nbeats - 1));
    end
    finish_stream();
    check("adv_count", adv_cnt, v.exp_adv);
    check("done_pulses", done_cnt, 1);
    check("beat_count", obs_cnt, v.exp_cnt);
    check("overflow", obs_ovf, v.exp_ovf);
    check("exp_q_drained", exp_q.size(), 0);
    if (v.sel == 0 && v.base == 0 && v.nbeats == 3) begin
      for (int n = 0; n < 6; n++) begin
        check("lane0_hist", hist0[n+1], l0_ref[n]);
        check("lane3_hist", hist3[n+1], l3_ref[n]);
      end
    end
    mon_on = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int dcount, lowc;

    tbl[0] = '{0, 0, 3, 0, 1'b1, 3, 1'b0, 6};
    tbl[1] = '{0, 0, 3, 2, 1'b1, 3, 1'b0, 6};
    tbl[2] = '{2, -1, 1, 0, 1'b1, 1, 1'b0, 16};
    tbl[3] = '{1, 0, 6, 0, 1'b0, 4, 1'b1, 7};
    tbl[4] = '{1, 100, 2, 0, 1'b1, 2, 1'b0, 5};
    l0_ref = '{0, 16, 32, 0, 0, 0};
    l3_ref = '{0, 0, 0, 3, 19, 35};

    RESET = 1'b1; in_valid = 1'b0; in_last = 1'b0; sel = 0;
    for (int i = 0; i < 16; i++) lane_d[i] = '0;
    repeat (3) @(negedge CLK);

    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1;
      check("rst_a_left", obs_a, 0);
      check("rst_en", obs_en, 0);
      check("rst_busy", obs_busy, 0);
      check("rst_done", obs_done, 0);
      check("rst_cnt", obs_cnt, 0);
      check("rst_ovf", obs_ovf, 0);
      check("rst_ready", obs_ready, 1);
    end
    sel = 0;
    @(negedge CLK);
    RESET = 1'b0;
    @(negedge CLK);

    for (int t = 0; t < 5; t++) run_stream(tbl[t]);

    // Reset in the middle of draining a 5-beat stream.
    sel = 0;
    #1;
    for (int j = 0; j < 5; j++) drive_beat(0, j, j == 4);
    in_valid = 1'b0;
    in_last  = 1'b0;
    @(negedge CLK);
    check("pre_rst_busy", obs_busy, 1);
    check("pre_rst_cnt", obs_cnt, 5);
    RESET = 1'b1;
    @(negedge CLK);
    check("mid_rst_a_left", obs_a, 0);
    check("mid_rst_en", obs_en, 0);
    check("mid_rst_busy", obs_busy, 0);
    check("mid_rst_cnt", obs_cnt, 0);
    check("mid_rst_done", obs_done, 0);
    RESET = 1'b0;
    dcount = 0;
    repeat (6) begin
      @(negedge CLK);
      if (obs_done) dcount++;
    end
    check("no_done_after_rst", dcount, 0);
    run_stream(tbl[0]);

    // Back-to-back streams, producer never drops in_valid.
    sel = 0;
    #1;
    exp_q.delete();
    push_expected(0, 4, 2);
    push_expected(256, 4, 2);
    adv_cnt  = 0;
    done_cnt = 0;
    mon_on   = 1'b1;
    drive_beat(0, 0, 1'b0);
    drive_beat(0, 1, 1'b1);
    for (int i = 0; i < 16; i++) lane_d[i] = elem(256, 0, i);
    in_last  = 1'b0;
    in_valid = 1'b1;
    lowc = 0;
    while (!obs_ready && lowc < 20) begin
      lowc++;
      @(negedge CLK);
    end
    check("b2b_ready_low_cycles", lowc, 3);
    check("b2b_done_at_accept", obs_done, 1);
    @(negedge CLK);
    drive_beat(256, 1, 1'b1);
    finish_stream();
    check("b2b_adv_count", adv_cnt, 10);
    check("b2b_done_pulses", done_cnt, 2);
    check("b2b_beat_count", obs_cnt, 2);
    check("b2b_exp_q_drained", exp_q.size(), 0);
    mon_on = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
